// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game and its automatic player.
// State codes are also decoded by the game's 7-segment debug display.
package jogo_pkg;

  localparam int N_JOGADAS_DEF = 16;

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PULSO      = 4'd1,
    ESPERA     = 4'd2,
    CARREGA    = 4'd3,
    APRESENTA  = 4'd4,
    LIBERA     = 4'd5,
    ESPERA_FIM = 4'd6,
    FIM_OK     = 4'd10,
    FIM_ERRO   = 4'd14
  } estado_t;

  localparam logic [3:0] CHAVE_0 = 4'b0001;
  localparam logic [3:0] CHAVE_1 = 4'b0010;
  localparam logic [3:0] CHAVE_2 = 4'b0100;
  localparam logic [3:0] CHAVE_3 = 4'b1000;

endpackage

// File: rtl/jogador_automatico_if.sv
// Bundle between the automatic player (master) and the game (slave):
// sequence ROM port, start pulse, switch lines and game result.
interface jogador_automatico_if;
  logic [3:0] rom_endereco;
  logic [3:0] rom_dado;
  logic       iniciar_out;
  logic [3:0] chaves_out;
  logic       pronto_in;
  logic       acertou_in;
  logic       errou_in;

  modport master (
    output rom_endereco, iniciar_out, chaves_out,
    input  rom_dado, pronto_in, acertou_in, errou_in
  );

  modport slave (
    input  rom_endereco, iniciar_out, chaves_out,
    output rom_dado, pronto_in, acertou_in, errou_in
  );
endinterface

// File: rtl/contador_param.sv
// Up-counter 0..MODULO-1 with synchronous clear, enable and
// terminal-count flag; wraps or saturates at the terminal value.
module contador_param #(
  parameter int MODULO = 16,
  parameter int W      = 4,
  parameter bit SATURA = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         tc
);

  logic [W-1:0] q_q, q_d;

  assign tc = (q_q == W'(MODULO - 1));
  assign q  = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      if (!tc)         q_d = q_q + W'(1);
      else if (!SATURA) q_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: replays the game's ROM sequence on the switch
// lines, optionally corrupting one round, and grades the game's result.
module jogador_automatico
  import jogo_pkg::*;
#(
  parameter int N_JOGADAS   = N_JOGADAS_DEF,
  parameter int HOLD_CYCLES = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 comecar,
  input  logic                 injeta_erro,
  input  logic [3:0]           erro_pos,
  jogador_automatico_if.master jogo,
  output logic                 fim,
  output logic                 passou,
  output logic                 falhou,
  output logic [3:0]           db_estado,
  output logic [3:0]           db_jogada
);

  localparam int RW = $clog2(N_JOGADAS);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT);

  estado_t estado_q, estado_d;
  logic       inj_q, inj_d;
  logic [3:0] pos_q, pos_d;
  logic [3:0] stim_q, stim_d;
  logic [3:0] estimulo;

  logic [RW-1:0] rodada;
  logic          rod_clr, rod_en, rod_tc;
  logic [HW-1:0] hold;
  logic          hold_tc;
  logic [TW-1:0] tmo_unused;
  logic          tmo_tc;
  logic          em_jogo, corrompe, sucesso;

  contador_param #(.MODULO(N_JOGADAS), .W(RW), .SATURA(1'b0)) u_rodada (
    .clock(clock), .reset(reset), .clr(rod_clr), .en(rod_en),
    .q(rodada), .tc(rod_tc)
  );

  contador_param #(.MODULO(HOLD_CYCLES), .W(HW), .SATURA(1'b0)) u_hold (
    .clock(clock), .reset(reset),
    .clr(estado_q != APRESENTA), .en(estado_q == APRESENTA),
    .q(hold), .tc(hold_tc)
  );

  contador_param #(.MODULO(TIMEOUT), .W(TW), .SATURA(1'b1)) u_tmo (
    .clock(clock), .reset(reset),
    .clr(estado_q != ESPERA_FIM), .en(estado_q == ESPERA_FIM),
    .q(tmo_unused), .tc(tmo_tc)
  );

  assign em_jogo  = estado_q inside {PULSO, ESPERA, CARREGA,
                                     APRESENTA, LIBERA, ESPERA_FIM};
  assign corrompe = inj_q && (4'(rodada) == pos_q);

  always_comb begin
    estimulo = jogo.rom_dado;
    if (corrompe) begin
      estimulo = (jogo.rom_dado == '0) ? CHAVE_0
               : {jogo.rom_dado[2:0], jogo.rom_dado[3]};
    end
  end

  always_comb begin
    sucesso = jogo.acertou_in && !jogo.errou_in && rod_tc;
    if (inj_q) begin
      sucesso = jogo.errou_in && !jogo.acertou_in
             && (4'(rodada) == pos_q);
    end
  end

  always_comb begin
    estado_d = estado_q;
    inj_d    = inj_q;
    pos_d    = pos_q;
    stim_d   = stim_q;
    rod_clr  = 1'b0;
    rod_en   = 1'b0;
    unique case (estado_q)
      INICIAL, FIM_OK, FIM_ERRO: begin
        if (comecar) begin
          estado_d = PULSO;
          inj_d    = injeta_erro;
          pos_d    = erro_pos;
          rod_clr  = 1'b1;
        end
      end
      PULSO:   estado_d = ESPERA;
      ESPERA:  estado_d = CARREGA;
      CARREGA: estado_d = APRESENTA;
      APRESENTA: begin
        // ROM data is valid from the first hold cycle; keep it from there.
        if (hold == '0) stim_d = estimulo;
        if (hold_tc)    estado_d = LIBERA;
      end
      LIBERA: begin
        if (rod_tc) begin
          estado_d = ESPERA_FIM;
        end else begin
          rod_en   = 1'b1;
          estado_d = CARREGA;
        end
      end
      ESPERA_FIM: if (tmo_tc) estado_d = FIM_ERRO;
      default: estado_d = INICIAL;
    endcase
    if (em_jogo && jogo.pronto_in) begin
      estado_d = (estado_q != PULSO && sucesso) ? FIM_OK : FIM_ERRO;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      inj_q    <= 1'b0;
      pos_q    <= '0;
      stim_q   <= '0;
    end else begin
      estado_q <= estado_d;
      inj_q    <= inj_d;
      pos_q    <= pos_d;
      stim_q   <= stim_d;
    end
  end

  always_comb begin
    jogo.chaves_out = '0;
    if (estado_q == APRESENTA) begin
      jogo.chaves_out = (hold == '0) ? estimulo : stim_q;
    end
  end

  assign jogo.rom_endereco = 4'(rodada);
  assign jogo.iniciar_out  = (estado_q == PULSO);
  assign fim       = (estado_q == FIM_OK) || (estado_q == FIM_ERRO);
  assign passou    = (estado_q == FIM_OK);
  assign falhou    = (estado_q == FIM_ERRO);
  assign db_estado = estado_q;
  assign db_jogada = 4'(rodada);

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: timeline model of one run, scripted game.
module tb_jogador_automatico;
  import jogo_pkg::*;

  localparam int NJ   = 16;
  localparam int HOLD = 3;
  localparam int TMO  = 64;
  localparam int PER  = HOLD + 2;
  localparam int LAST = 3 + NJ * PER;

  logic       clk;
  logic       reset;
  logic       comecar;
  logic       injeta_erro;
  logic [3:0] erro_pos;
  logic       fim, passou, falhou;
  logic [3:0] db_estado, db_jogada;
  logic [3:0] rom_mem [16];

  int checks   = 0;
  int failures = 0;

  jogador_automatico_if jogo ();

  jogador_automatico #(
    .N_JOGADAS(NJ), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
  ) dut (
    .clock(clk), .reset(reset), .comecar(comecar),
    .injeta_erro(injeta_erro), .erro_pos(erro_pos),
    .jogo(jogo), .fim(fim), .passou(passou), .falhou(falhou),
    .db_estado(db_estado), .db_jogada(db_jogada)
  );

  always #5 clk = ~clk;

  always @(posedge clk) jogo.rom_dado <= rom_mem[jogo.rom_endereco];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int est_exp(int t);
    int k;
    if (t == 1) return 1;
    if (t == 2) return 2;
    if (t >= LAST) return 6;
    k = (t - 3) % PER;
    if (k == 0) return 3;
    if (k <= HOLD) return 4;
    return 5;
  endfunction

  function automatic int rod_exp(int t);
    if (t < 3) return 0;
    if (t >= LAST) return NJ - 1;
    return (t - 3) / PER;
  endfunction

  function automatic int stim_exp(int v, bit corrupt);
    if (!corrupt) return v;
    if (v == 0) return 1;
    return ((v * 2) % 16) + (v / 8);
  endfunction

  // Caller is 1ns after a posedge with the DUT idle or finished.
  task automatic run(input bit inj, input logic [3:0] pos,
                     input int tp, input bit ac, input bit er,
                     input int tsp);
    int tend, r, e, ch;
    bit ok;
    if (tp > 0 && tp < LAST + TMO) tend = tp + 1;
    else tend = LAST + TMO;
    ok = 1'b0;
    if (tend != LAST + TMO && tp != 1) begin
      r = rod_exp(tp);
      if (inj) ok = er && !ac && (r == int'(pos));
      else     ok = ac && !er && (r == NJ - 1);
    end
    injeta_erro = inj;
    erro_pos    = pos;
    comecar     = 1'b1;
    for (int t = 1; t <= tend + 1; t++) begin
      @(posedge clk); #1;
      if (t < tend) begin
        e = est_exp(t);
        r = rod_exp(t);
        ch = 0;
        if (e == 4) ch = stim_exp(rom_mem[r], inj && r == int'(pos));
        chk("estado", db_estado, e);
        chk("chaves", jogo.chaves_out, ch);
        chk("iniciar", jogo.iniciar_out, int'(t == 1));
        chk("jogada", db_jogada, r);
        chk("endereco", jogo.rom_endereco, r);
        chk("fim_run", fim, 0);
        chk("passou_run", passou, 0);
        chk("falhou_run", falhou, 0);
      end else begin
        chk("estado_fim", db_estado, ok ? 10 : 14);
        chk("fim", fim, 1);
        chk("passou", passou, int'(ok));
        chk("falhou", falhou, int'(!ok));
        chk("chaves_fim", jogo.chaves_out, 0);
        chk("iniciar_fim", jogo.iniciar_out, 0);
      end
      comecar = (t == tsp) && (tsp < tend);
      if (comecar) begin
        injeta_erro = !inj;
        erro_pos    = pos + 4'd1;
      end
      jogo.pronto_in  = (t == tp);
      jogo.acertou_in = (t == tp) && ac;
      jogo.errou_in   = (t == tp) && er;
    end
    comecar         = 1'b0;
    jogo.pronto_in  = 1'b0;
    jogo.acertou_in = 1'b0;
    jogo.errou_in   = 1'b0;
  endtask

  task automatic reset_mid_run();
    int tr;
    tr = 3 + 5 * PER + 2;
    injeta_erro = 1'b0;
    erro_pos    = 4'd0;
    comecar     = 1'b1;
    for (int t = 1; t <= tr; t++) begin
      @(posedge clk); #1;
      comecar = 1'b0;
    end
    chk("rst_pre_estado", db_estado, 4);
    chk("rst_pre_jogada", db_jogada, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_estado", db_estado, 0);
    chk("rst_chaves", jogo.chaves_out, 0);
    chk("rst_jogada", db_jogada, 0);
    comecar = 1'b1;
    @(posedge clk); #1;
    chk("rst_vs_comecar", db_estado, 0);
    reset   = 1'b0;
    comecar = 1'b0;
    @(posedge clk); #1;
    chk("rst_post_estado", db_estado, 0);
    chk("rst_post_chaves", jogo.chaves_out, 0);
    chk("rst_post_fim", fim, 0);
    chk("rst_post_passou", passou, 0);
    chk("rst_post_falhou", falhou, 0);
    chk("rst_post_iniciar", jogo.iniciar_out, 0);
  endtask

  initial begin
    bit inj, ac, er;
    logic [3:0] pos;
    int r, tp;
    clk = 1'b0;
    reset = 1'b1;
    comecar = 1'b0;
    injeta_erro = 1'b0;
    erro_pos = 4'd0;
    jogo.pronto_in = 1'b0;
    jogo.acertou_in = 1'b0;
    jogo.errou_in = 1'b0;
    for (int i = 0; i < 16; i++) rom_mem[i] = 4'(1 << (i % 4));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_estado", db_estado, 0);
    chk("reset_chaves", jogo.chaves_out, 0);
    chk("reset_fim", fim, 0);
    chk("reset_passou", passou, 0);
    chk("reset_falhou", falhou, 0);
    chk("reset_iniciar", jogo.iniciar_out, 0);
    chk("reset_endereco", jogo.rom_endereco, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_estado", db_estado, 0);

    run(1'b0, 4'd0, 3 + 15 * PER + 4, 1'b1, 1'b0, 3 + 7 * PER + 2);
    run(1'b1, 4'd3, 3 + 3 * PER + 4, 1'b0, 1'b1, 0);
    run(1'b1, 4'd2, 3 + 15 * PER + 4, 1'b1, 1'b0, 0);
    run(1'b0, 4'd0, 0, 1'b0, 1'b0, 0);
    run(1'b0, 4'd0, 1, 1'b1, 1'b0, 0);
    run(1'b0, 4'd0, LAST + 5, 1'b1, 1'b0, 0);
    rom_mem[6] = 4'd0;
    run(1'b1, 4'd6, 3 + 6 * PER + 2, 1'b0, 1'b1, 0);

    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 16; i++) rom_mem[i] = 4'($urandom_range(0, 15));
      inj = 1'($urandom_range(0, 1));
      pos = 4'($urandom_range(0, 15));
      r = inj ? int'(pos) : NJ - 1;
      case ($urandom_range(0, 2))
        0:       tp = 3 + r * PER + $urandom_range(0, PER - 1);
        1:       tp = $urandom_range(1, LAST + TMO + 4);
        default: tp = 0;
      endcase
      ac = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 3) == 0) ? ac : !ac;
      run(inj, pos, tp, ac, er, $urandom_range(2, 60));
    end

    reset_mid_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
